// File: rtl/cfg_pkg.sv
// Shared constants and types for the tile configuration loader.
// Frame geometry, state encoding and bus payload types live here.
package cfg_pkg;

  localparam int unsigned NUM_TILES       = 4;
  localparam int unsigned FRAME_W         = 77;
  localparam int unsigned IN_W            = 8;
  localparam int unsigned BYTES_PER_FRAME = (FRAME_W + IN_W - 1) / IN_W;
  localparam int unsigned TILE_W          = $clog2(NUM_TILES);
  localparam int unsigned CNT_W           = $clog2(BYTES_PER_FRAME);

  typedef enum logic [2:0] {IDLE, LOAD, WRITE, CHECK, DONE} cfg_state_t;

  typedef logic [FRAME_W-1:0]   cfg_frame_t;
  typedef logic [IN_W-1:0]      cfg_byte_t;
  typedef logic [TILE_W-1:0]    cfg_tile_t;
  typedef logic [NUM_TILES-1:0] cfg_wr_en_t;

endpackage

// File: rtl/cfg_loader_if.sv
// Bitstream input handshake plus tile write bus of the configuration loader.
// master = bitstream source / tile side, slave = the loader.
interface cfg_loader_if;
  import cfg_pkg::*;

  logic       start;
  cfg_byte_t  din;
  logic       din_valid;
  logic       din_ready;
  cfg_frame_t bits;
  cfg_wr_en_t wr_en;
  cfg_tile_t  tile_idx;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output start, din, din_valid,
    input  din_ready, bits, wr_en, tile_idx, busy, done, err
  );

  modport slave (
    input  start, din, din_valid,
    output din_ready, bits, wr_en, tile_idx, busy, done, err
  );

endinterface

// File: rtl/cfg_frame_asm.sv
// Byte counter and frame assembly register: packs IN_W-wide bytes LSB-first
// into one FRAME_W frame; bytes landing above the frame width are dropped.
module cfg_frame_asm
  import cfg_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       byte_en,
  input  cfg_byte_t  din,
  output cfg_frame_t frame_c,
  output logic       frame_full_c
);

  localparam cfg_frame_t BYTE_MASK = FRAME_W'({IN_W{1'b1}});

  logic [CNT_W-1:0] cnt_q, cnt_d;
  cfg_frame_t       asm_q, asm_d;
  logic [31:0]      shift_c;

  // frame_c is the assembly value including the byte accepted this cycle
  always_comb begin
    cnt_d        = cnt_q;
    asm_d        = asm_q;
    shift_c      = 32'(cnt_q) * IN_W;
    frame_full_c = byte_en && (cnt_q == CNT_W'(BYTES_PER_FRAME - 1));
    if (clear) begin
      cnt_d = '0;
      asm_d = '0;
    end else if (byte_en) begin
      asm_d = (asm_q & ~(BYTE_MASK << shift_c)) | (FRAME_W'(din) << shift_c);
      cnt_d = frame_full_c ? '0 : cnt_q + CNT_W'(1);
    end
    frame_c = asm_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      asm_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      asm_q <= asm_d;
    end
  end

endmodule

// File: rtl/cfg_loader.sv
// Tile configuration loader: assembles one frame per tile from a byte stream,
// strobes it into each tile in turn and verifies a trailing XOR checksum.
module cfg_loader
  import cfg_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  cfg_loader_if.slave  bus
);

  cfg_state_t state_q, state_d;
  cfg_tile_t  tile_q, tile_d;
  cfg_byte_t  acc_q, acc_d;
  cfg_frame_t bits_q, bits_d;
  cfg_wr_en_t wr_en_q, wr_en_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;

  logic       din_ready_c;
  logic       accept_c;
  logic       asm_clear_c;
  logic       asm_byte_en_c;
  cfg_frame_t frame_c;
  logic       frame_full_c;

  assign din_ready_c   = (state_q == LOAD) || (state_q == CHECK);
  assign accept_c      = bus.din_valid && din_ready_c;
  assign asm_byte_en_c = accept_c && (state_q == LOAD);

  cfg_frame_asm u_frame_asm (
    .clk          (clk),
    .reset        (reset),
    .clear        (asm_clear_c),
    .byte_en      (asm_byte_en_c),
    .din          (bus.din),
    .frame_c      (frame_c),
    .frame_full_c (frame_full_c)
  );

  always_comb begin
    state_d     = state_q;
    tile_d      = tile_q;
    acc_d       = acc_q;
    bits_d      = bits_q;
    wr_en_d     = '0;
    err_d       = err_q;
    asm_clear_c = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d     = LOAD;
          tile_d      = '0;
          acc_d       = '0;
          err_d       = 1'b0;
          asm_clear_c = 1'b1;
        end
      end
      LOAD: begin
        if (accept_c) begin
          acc_d = acc_q ^ bus.din;
          // bits and the strobe are registered together so bits is stable under wr_en
          if (frame_full_c) begin
            state_d = WRITE;
            bits_d  = frame_c;
            wr_en_d = NUM_TILES'(1) << tile_q;
          end
        end
      end
      WRITE: begin
        if (tile_q == TILE_W'(NUM_TILES - 1)) begin
          state_d = CHECK;
        end else begin
          state_d = LOAD;
          tile_d  = tile_q + TILE_W'(1);
        end
      end
      CHECK: begin
        if (accept_c) begin
          err_d   = (acc_q ^ bus.din) != '0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE) && (state_d != DONE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      tile_q  <= '0;
      acc_q   <= '0;
      bits_q  <= '0;
      wr_en_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tile_q  <= tile_d;
      acc_q   <= acc_d;
      bits_q  <= bits_d;
      wr_en_q <= wr_en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.din_ready = din_ready_c;
  assign bus.bits      = bits_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.tile_idx  = tile_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: doc/cfg_loader.md
Name: cfg_loader

Overview:
- Upstream configuration stage for the tile array.
- Accepts a byte-serial bitstream over a valid/ready handshake and assembles one 77-bit configuration frame per tile.
- Writes each frame into its tile by driving the shared `bits` bus together with a one-cycle, one-hot `wr_en` strobe.
- Closes the load with an XOR checksum byte and reports pass/fail.

Parameters:
- NUM_TILES, 4, number of tiles configured per load; tile 0 first.
- FRAME_W, 77, configuration bits per tile.
- IN_W, 8, input data width.
- BYTES_PER_FRAME, ceil(FRAME_W/IN_W) = 10, derived; do not override.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a load; sampled only in IDLE.
- din  in  IN_W  bitstream byte.
- din_valid  in  1  din holds a valid byte.
- din_ready  out  1  loader accepts din this cycle.
- bits  out  FRAME_W  frame to tiles; broadcast to all tiles.
- wr_en  out  NUM_TILES  one-hot tile write strobe.
- tile_idx  out  $clog2(NUM_TILES)  tile currently being loaded.
- busy  out  1  high in any state other than IDLE and DONE.
- done  out  1  load complete; level signal.
- err  out  1  checksum mismatch; valid while done=1.

Behaviour:
- Reset values (asynchronous, takes effect immediately):
  - state=IDLE.
  - bits=0, wr_en=0, tile_idx=0, din_ready=0, busy=0, done=0, err=0.
  - Byte counter and checksum accumulator cleared.
- Handshake:
  - A byte transfers on a posedge where din_valid && din_ready.
  - din_ready is a combinational function of state: high only in LOAD and CHECK.
- IDLE:
  - start=1 moves to LOAD; byte count=0, tile_idx=0, accumulator=0, done=0, err=0.
- LOAD:
  - Each accepted byte k (0..9) is stored into assembly register positions [8k+7:8k]; byte 0 is the LSBs.
  - Assembly bits above FRAME_W-1 are discarded. For the last byte only din[4:0] is used; din[7:5] are ignored by the frame but still XORed into the checksum.
  - Every accepted byte is XORed into the accumulator.
  - On acceptance of byte 9, the next state is WRITE.
- WRITE (exactly 1 cycle):
  - bits is registered from the assembly register on entry and presented in this cycle.
  - wr_en[tile_idx]=1 in this cycle; all other wr_en bits are 0.
  - Next state:
    - If tile_idx==NUM_TILES-1: go to CHECK.
    - Otherwise: tile_idx++, byte count=0, go to LOAD.
- bits holding rule:
  - bits changes only on entry to WRITE.
  - Otherwise it holds its value, including after the strobe, so it stays stable for a tile sampling on the wr_en edge.
- CHECK:
  - Accept one checksum byte.
  - err = (accumulator ^ byte) != 0.
  - Next state is DONE.
- DONE:
  - done=1, err held.
  - start=1 re-arms: same action as IDLE+start; done and err clear on the next edge.
- start outside IDLE/DONE is ignored.
- din_valid low stalls indefinitely with no state change; no timeout.
- Reset asserted mid-load: immediate return to IDLE. Any wr_en pulse in flight is cancelled; a partial frame is never written.
- Latency: the wr_en strobe occurs one cycle after byte 9 is accepted. Minimum load time = NUM_TILES*11 + 1 cycles at full throughput.

Decomposition:
- Package cfg_pkg holds:
  - localparams FRAME_W=77, IN_W=8, BYTES_PER_FRAME.
  - typedef enum logic [2:0] {IDLE, LOAD, WRITE, CHECK, DONE} cfg_state_t.
  - typedef logic [FRAME_W-1:0] cfg_frame_t.
- One natural sub-module, cfg_frame_asm:
  - Contains the byte counter plus the assembly register.
  - Outputs frame_full for the FSM.
- The FSM, checksum accumulator and tile index stay in cfg_loader.

Test Plan:
- Reset, then start with 41 bytes streamed back-to-back: tile k frames are all bytes 0x11*(k+1); checksum byte = XOR of the 40 data bytes.
  - Each wr_en is one-hot in order 0001, 0010, 0100, 1000, exactly one cycle each.
  - bits = byte pattern replicated, truncated to 77 bits.
  - done=1, err=0.
- Same stream with the checksum byte XOR 0x01 -> done=1, err=1; all four writes still occur.
- din_valid toggled 1/0 every cycle during the load -> identical bits/wr_en sequence to the back-to-back case. din_ready is never high in WRITE; the total cycle count roughly doubles.
- Reset asserted after 6 bytes of tile 2:
  - All outputs zero immediately; no wr_en[2].
  - A subsequent start restarts cleanly at tile 0.
- Byte 9 = 0xFF, bytes 0..8 = 0x00 -> bits = 77'h1F << 72 (upper 3 bits dropped). Accumulator still includes 0xFF, so a checksum of 0xFF gives err=0.
- start pulsed during LOAD -> no effect. start in DONE -> done falls next cycle and a new load begins at tile 0.
